spike_rr_arbiter: RTL and testbench

- Upstream of the neuron-array select mux and one-hot decoder: collects single-cycle spike pulses from INPUTS neuron sources, latches them as pending events, and serialises them one at a time.
- Arbitration is round-robin. Each event is presented as a binary index, the mux select, plus a matching one-hot grant, the decoder-equivalent.
- A valid/ready handshake lets the downstream consumer (synapse/routing stage) apply backpressure without losing events, up to one pending event per source.

---
 rtl/spike_rr_arbiter.sv | 71 +++++++
 tb/tb_spike_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/spike_rr_arbiter.sv
// Round-robin spike event arbiter: latches per-source spike pulses as pending
// events and serialises them as binary index plus one-hot grant over valid/ready.
module spike_rr_arbiter #(
   parameter int INPUTS = 8,
   localparam int IDX_W = $clog2(INPUTS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [INPUTS-1:0] spike_in,
   input  logic              clear_ovf,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [IDX_W-1:0]  out_idx,
   output logic [INPUTS-1:0] out_onehot,
   output logic [INPUTS-1:0] pending,
   output logic [INPUTS-1:0] ovf
);

   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  sel;
   logic              found;
   logic              load;
   logic [INPUTS-1:0] sel_oh;
   logic [INPUTS-1:0] consume;
   logic [INPUTS-1:0] drop;

   // Scan ptr+1 .. ptr (wrapping at INPUTS-1) so ptr itself is checked last.
   always_comb begin
      int j;
      sel   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= INPUTS; k++) begin
         j = int'(ptr) + k;
         if (j >= INPUTS) j = j - INPUTS;
         if (!found && pending[j]) begin
            found = 1'b1;
            sel   = IDX_W'(j);
         end
      end
   end

   assign load    = found && (!out_valid || out_ready);
   assign sel_oh  = INPUTS'(1) << sel;
   assign consume = load ? sel_oh : '0;
   assign drop    = spike_in & pending & ~consume;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending    <= '0;
         ovf        <= '0;
         out_valid  <= 1'b0;
         out_idx    <= '0;
         out_onehot <= '0;
         ptr        <= IDX_W'(INPUTS - 1);
      end else begin
         pending <= (pending & ~consume) | spike_in;
         ovf     <= (clear_ovf ? '0 : ovf) | drop;
         if (load) begin
            out_valid  <= 1'b1;
            out_idx    <= sel;
            out_onehot <= sel_oh;
            ptr        <= sel;
         end else if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            out_onehot <= '0;
         end
      end
   end

endmodule

// File: tb/tb_spike_rr_arbiter.sv
// Scoreboard bench for spike_rr_arbiter: an 8-source and a 5-source instance,
// expected grants queued by the stimulus and popped by per-instance monitors.
module tb_spike_rr_arbiter;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst8, clr8, r8, v8;
   logic [7:0] s8, oh8, p8, o8;
   logic [2:0] idx8;

   logic       rst5, clr5, r5, v5;
   logic [4:0] s5, oh5, p5, o5;
   logic [2:0] idx5;

   int checks = 0;
   int failures = 0;
   int q8[$];
   int q5[$];

   spike_rr_arbiter #(.INPUTS(8)) u8 (
      .clk(clk), .rst_n(rst8), .spike_in(s8), .clear_ovf(clr8),
      .out_valid(v8), .out_ready(r8), .out_idx(idx8),
      .out_onehot(oh8), .pending(p8), .ovf(o8)
   );

   spike_rr_arbiter #(.INPUTS(5)) u5 (
      .clk(clk), .rst_n(rst5), .spike_in(s5), .clear_ovf(clr5),
      .out_valid(v5), .out_ready(r5), .out_idx(idx5),
      .out_onehot(oh5), .pending(p5), .ovf(o5)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic reset8();
      rst8 = 1'b0;
      tick();
      rst8 = 1'b1;
      tick();
   endtask

   // Monitors: a transfer happens at the next rising edge when valid & ready.
   always @(negedge clk) begin
      int e;
      if (rst8 && v8 && r8) begin
         if (q8.size() == 0) chk("sb8_unexpected", int'(idx8), -1);
         else begin
            e = q8.pop_front();
            chk("sb8_idx", int'(idx8), e);
            chk("sb8_onehot", int'(oh8), 1 << e);
         end
      end
   end

   always @(negedge clk) begin
      int e;
      if (rst5 && v5 && r5) begin
         chk("sb5_range", int'(idx5 <= 3'd4), 1);
         if (q5.size() == 0) chk("sb5_unexpected", int'(idx5), -1);
         else begin
            e = q5.pop_front();
            chk("sb5_idx", int'(idx5), e);
            chk("sb5_onehot", int'(oh5), 1 << e);
         end
      end
   end

   initial begin
      rst8 = 1'b0; clr8 = 1'b0; r8 = 1'b1; s8 = '0;
      rst5 = 1'b0; clr5 = 1'b0; r5 = 1'b1; s5 = '0;
      repeat (2) tick();
      chk("rst_valid", int'(v8), 0);
      chk("rst_idx", int'(idx8), 0);
      chk("rst_onehot", int'(oh8), 0);
      chk("rst_pending", int'(p8), 0);
      chk("rst_ovf", int'(o8), 0);
      rst8 = 1'b1;
      rst5 = 1'b1;
      tick();

      // single spike, two-cycle latency
      q8.push_back(2);
      s8 = 8'h04;
      tick();
      s8 = '0;
      chk("t1_pend_k1", int'(p8), 8'h04);
      chk("t1_valid_k1", int'(v8), 0);
      tick();
      chk("t1_valid_k2", int'(v8), 1);
      chk("t1_idx_k2", int'(idx8), 2);
      chk("t1_onehot_k2", int'(oh8), 8'h04);
      chk("t1_pend_k2", int'(p8), 0);
      tick();
      chk("t1_valid_k3", int'(v8), 0);

      // all sources at once, from reset pointer
      reset8();
      for (int i = 0; i < 8; i++) q8.push_back(i);
      s8 = 8'hFF;
      tick();
      s8 = '0;
      repeat (10) tick();
      chk("t2_valid_end", int'(v8), 0);
      chk("t2_ovf", int'(o8), 0);
      chk("t2_pending", int'(p8), 0);

      // fairness: after grant to 3, sources 0 and 3 go 0 then 3
      reset8();
      q8.push_back(3);
      q8.push_back(0);
      q8.push_back(3);
      s8 = 8'h08;
      tick();
      s8 = '0;
      repeat (3) tick();
      s8 = 8'h09;
      tick();
      s8 = '0;
      repeat (4) tick();
      chk("t3_valid_end", int'(v8), 0);

      // backpressure, overflow, clear
      reset8();
      r8 = 1'b0;
      q8.push_back(5);
      q8.push_back(5);
      s8 = 8'h20;
      tick();
      s8 = '0;
      tick();
      chk("t4_valid", int'(v8), 1);
      chk("t4_idx", int'(idx8), 5);
      s8 = 8'h20;
      tick();
      s8 = '0;
      chk("t4_pend5", int'(p8), 8'h20);
      chk("t4_idx_hold", int'(idx8), 5);
      chk("t4_oh_hold", int'(oh8), 8'h20);
      chk("t4_ovf_none", int'(o8), 0);
      s8 = 8'h20;
      tick();
      s8 = '0;
      chk("t4_ovf5", int'(o8), 8'h20);
      chk("t4_idx_hold2", int'(idx8), 5);
      clr8 = 1'b1;
      tick();
      clr8 = 1'b0;
      chk("t4_ovf_clr", int'(o8), 0);
      r8 = 1'b1;
      repeat (4) tick();
      chk("t4_valid_end", int'(v8), 0);
      chk("t4_pend_end", int'(p8), 0);

      // re-spike on source 1 in the cycle it is consumed
      reset8();
      q8.push_back(1);
      q8.push_back(1);
      s8 = 8'h02;
      tick();
      tick();
      s8 = '0;
      chk("t5_valid", int'(v8), 1);
      chk("t5_idx", int'(idx8), 1);
      chk("t5_pend_kept", int'(p8), 8'h02);
      chk("t5_ovf", int'(o8), 0);
      tick();
      chk("t5_regrant", int'(idx8), 1);
      chk("t5_pend_end", int'(p8), 0);
      tick();
      chk("t5_valid_end", int'(v8), 0);

      // five sources, repeated bursts
      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 5; i++) q5.push_back(i);
         s5 = 5'h1F;
         tick();
         s5 = '0;
         repeat (7) tick();
      end
      chk("t6_ovf", int'(o5), 0);

      // reset mid-stream: only source 0 completes before it
      q5.push_back(0);
      s5 = 5'h1F;
      tick();
      s5 = '0;
      repeat (2) tick();
      #1 rst5 = 1'b0;
      #1;
      chk("t6_rst_valid", int'(v5), 0);
      chk("t6_rst_idx", int'(idx5), 0);
      chk("t6_rst_onehot", int'(oh5), 0);
      chk("t6_rst_pending", int'(p5), 0);
      chk("t6_rst_ovf", int'(o5), 0);
      tick();
      rst5 = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) q5.push_back(i);
      s5 = 5'h1F;
      tick();
      s5 = '0;
      tick();
      chk("t6_first_valid", int'(v5), 1);
      chk("t6_first_idx", int'(idx5), 0);
      repeat (6) tick();

      chk("q8_drained", q8.size(), 0);
      chk("q5_drained", q5.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
